// File: rtl/madd_cfg_sequencer_if.sv
// rtl/madd_cfg_sequencer_if.sv - tap request, result and DSP-side signal bundle for madd_cfg_sequencer
//
// Purpose: groups every non-clock/reset port of madd_cfg_sequencer.
//   slave  : the sequencer's view (consumes requests, produces results, drives the DSP).
//   master : the environment's view (issues taps, accepts results, models the DSP).
//
// Signals:
//   req_valid_i/req_ready_o/req_a_i[9:0]/req_b_i[8:0]/req_last_i : tap request stream
//   res_valid_o/res_ready_i/res_data_o[18:0]/res_taps_o[2:0]      : burst result stream
//   err_overflow_o                                                : sticky tap-overflow flag
//   dsp_*_o / dsp_z_i                                             : multiply-add DSP configuration and result

interface madd_cfg_sequencer_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [9:0]  req_a_i;
  logic [8:0]  req_b_i;
  logic        req_last_i;

  logic        res_valid_o;
  logic        res_ready_i;
  logic [18:0] res_data_o;
  logic [2:0]  res_taps_o;
  logic        err_overflow_o;

  logic [9:0]  dsp_a_o;
  logic [8:0]  dsp_b_o;
  logic [2:0]  dsp_feedback_o;
  logic        dsp_load_acc_o;
  logic [2:0]  dsp_output_select_o;
  logic        dsp_unsigned_a_o;
  logic        dsp_unsigned_b_o;
  logic [18:0] dsp_z_i;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_last_i,
    output req_ready_o,
    output res_valid_o, res_data_o, res_taps_o, err_overflow_o,
    input  res_ready_i,
    output dsp_a_o, dsp_b_o, dsp_feedback_o, dsp_load_acc_o,
    output dsp_output_select_o, dsp_unsigned_a_o, dsp_unsigned_b_o,
    input  dsp_z_i
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_last_i,
    input  req_ready_o,
    input  res_valid_o, res_data_o, res_taps_o, err_overflow_o,
    output res_ready_i,
    input  dsp_a_o, dsp_b_o, dsp_feedback_o, dsp_load_acc_o,
    input  dsp_output_select_o, dsp_unsigned_a_o, dsp_unsigned_b_o,
    output dsp_z_i
  );
endinterface

// File: rtl/madd_cfg_sequencer.sv
// rtl/madd_cfg_sequencer.sv - sequences up to four multiply-add taps into a DSP and returns the burst result
//
// Purpose: accepts a burst of 1..4 taps, drives each one onto the DSP configuration
// ports for exactly one cycle (first tap loads the accumulator with the addend),
// waits LATENCY+1 cycles after the last tap, captures dsp_z_i and offers it on the
// result stream until it is taken.
//
// Parameters:
//   LATENCY    : cycles from a tap on the DSP ports to a valid dsp_z_i (1..7)
//   UNSIGNED_A : constant driven on dsp_unsigned_a_o
//   UNSIGNED_B : constant driven on dsp_unsigned_b_o
//
// Ports:
//   clock_i : clock, rising edge
//   reset_i : asynchronous active-high reset
//   bus     : madd_cfg_sequencer_if.slave (request, result, DSP-side signals)

module madd_cfg_sequencer #(
  parameter int   LATENCY    = 1,
  parameter logic UNSIGNED_A = 1'b1,
  parameter logic UNSIGNED_B = 1'b1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  madd_cfg_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  localparam logic [2:0] LP_WAIT_LOAD = LATENCY[2:0];

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_tap_idx;
  logic [2:0]  r_wait_cnt;
  logic [18:0] r_res_data;
  logic [2:0]  r_res_taps;
  logic        r_err_overflow;

  logic [9:0]  r_dsp_a;
  logic [8:0]  r_dsp_b;
  logic [2:0]  r_dsp_feedback;
  logic        r_dsp_load_acc;

  logic        w_ready;
  logic        w_accept;
  logic        w_first;
  logic        w_force_last;
  logic        w_last;
  logic        w_wait_done;
  logic        w_res_valid;
  logic        w_res_take;

  // Ready is gated by reset so it stays low while reset_i is high even though
  // the state register already reads IDLE; it rises as soon as reset releases.
  assign w_ready      = ((r_state == ST_IDLE) || (r_state == ST_BURST)) & ~reset_i;
  assign w_accept     = bus.req_valid_i & w_ready;
  assign w_first      = (r_tap_idx == 2'd0);
  // The fourth tap always closes the burst; there is no fifth accumulator slot.
  assign w_force_last = (r_tap_idx == 2'd3);
  assign w_last       = bus.req_last_i | w_force_last;
  assign w_wait_done  = (r_wait_cnt == 3'd0);
  assign w_res_valid  = (r_state == ST_RESULT);
  assign w_res_take   = w_res_valid & bus.res_ready_i;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_BURST: begin
        if (w_accept) begin
          w_state_nxt = w_last ? ST_WAIT : ST_BURST;
        end
      end
      ST_WAIT: begin
        if (w_wait_done) begin
          w_state_nxt = ST_RESULT;
        end
      end
      ST_RESULT: begin
        // Returning to IDLE only; a tap cannot be taken on the handshake cycle
        // because ready is low throughout RESULT.
        if (w_res_take) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Tap issue registers: non-zero for exactly the cycle after an accepted tap.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_dsp_a        <= '0;
      r_dsp_b        <= '0;
      r_dsp_feedback <= '0;
      r_dsp_load_acc <= 1'b0;
    end else if (w_accept) begin
      r_dsp_a        <= w_first ? bus.req_a_i : 10'd0;
      r_dsp_b        <= bus.req_b_i;
      r_dsp_feedback <= {1'b1, r_tap_idx};
      r_dsp_load_acc <= w_first;
    end else begin
      r_dsp_a        <= '0;
      r_dsp_b        <= '0;
      r_dsp_feedback <= '0;
      r_dsp_load_acc <= 1'b0;
    end
  end

  // Burst bookkeeping: tap index, wait countdown, result capture, overflow flag.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_tap_idx      <= '0;
      r_wait_cnt     <= '0;
      r_res_data     <= '0;
      r_res_taps     <= '0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tap_idx <= w_last ? 2'd0 : r_tap_idx + 2'd1;
        if (w_last) begin
          // The tap reaches the DSP one cycle after acceptance and z follows
          // LATENCY cycles later, so the countdown spans LATENCY+1 WAIT cycles.
          r_wait_cnt <= LP_WAIT_LOAD;
          r_res_taps <= {1'b0, r_tap_idx} + 3'd1;
        end
        if (w_force_last && !bus.req_last_i) begin
          r_err_overflow <= 1'b1;
        end
      end

      if (r_state == ST_WAIT) begin
        if (w_wait_done) begin
          r_res_data <= bus.dsp_z_i;
        end else begin
          r_wait_cnt <= r_wait_cnt - 3'd1;
        end
      end
    end
  end

  assign bus.req_ready_o         = w_ready;
  assign bus.res_valid_o         = w_res_valid;
  assign bus.res_data_o          = r_res_data;
  assign bus.res_taps_o          = r_res_taps;
  assign bus.err_overflow_o      = r_err_overflow;

  assign bus.dsp_a_o             = r_dsp_a;
  assign bus.dsp_b_o             = r_dsp_b;
  assign bus.dsp_feedback_o      = r_dsp_feedback;
  assign bus.dsp_load_acc_o      = r_dsp_load_acc;
  // Fixed DSP mode: accumulator output, signedness from parameters.
  assign bus.dsp_output_select_o = 3'd3;
  assign bus.dsp_unsigned_a_o    = UNSIGNED_A;
  assign bus.dsp_unsigned_b_o    = UNSIGNED_B;

endmodule

// File: tb/tb_madd_cfg_sequencer.sv
// tb/tb_madd_cfg_sequencer.sv - directed self-checking bench for madd_cfg_sequencer

module tb_madd_cfg_sequencer;

  localparam int          LAT0  = 1;
  localparam int          LAT1  = 7;
  localparam logic [18:0] ZJUNK = 19'h5A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  madd_cfg_sequencer_if if0 ();
  madd_cfg_sequencer_if if1 ();

  madd_cfg_sequencer #(.LATENCY(LAT0), .UNSIGNED_A(1'b1), .UNSIGNED_B(1'b1)) u_dut0 (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (if0)
  );

  madd_cfg_sequencer #(.LATENCY(LAT1), .UNSIGNED_A(1'b0), .UNSIGNED_B(1'b1)) u_dut1 (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (if1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tap0(input logic [9:0] a, input logic [8:0] b, input logic last);
    if0.req_valid_i = 1'b1;
    if0.req_a_i     = a;
    if0.req_b_i     = b;
    if0.req_last_i  = last;
    tick();
    if0.req_valid_i = 1'b0;
    if0.req_last_i  = 1'b0;
  endtask

  // Called in the cycle after the last tap is accepted; returns in the cycle
  // where the DUT samples dsp_z_i, with z driven to v.
  task automatic arm_z0(input logic [18:0] v);
    repeat (LAT0) tick();
    if0.dsp_z_i = v;
  endtask

  task automatic take_result0();
    if0.res_ready_i = 1'b1;
    tick();
    if0.res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (if0.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", if0.req_ready_o); end
    n_checks++; if (if0.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", if0.res_valid_o); end
    n_checks++; if (if0.res_data_o !== 19'h0) begin n_fail++; $display("FAIL rst_res_data: got %h want 0", if0.res_data_o); end
    n_checks++; if (if0.res_taps_o !== 3'd0) begin n_fail++; $display("FAIL rst_res_taps: got %0d want 0", if0.res_taps_o); end
    n_checks++; if (if0.err_overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", if0.err_overflow_o); end
    n_checks++; if ({if0.dsp_a_o, if0.dsp_b_o, if0.dsp_feedback_o, if0.dsp_load_acc_o} !== 23'h0) begin n_fail++; $display("FAIL rst_dsp_tap: got a=%h b=%h fb=%b ld=%b want zeros", if0.dsp_a_o, if0.dsp_b_o, if0.dsp_feedback_o, if0.dsp_load_acc_o); end
    n_checks++; if (if0.dsp_output_select_o !== 3'd3) begin n_fail++; $display("FAIL rst_outsel: got %0d want 3", if0.dsp_output_select_o); end
    n_checks++; if ({if0.dsp_unsigned_a_o, if0.dsp_unsigned_b_o} !== 2'b11) begin n_fail++; $display("FAIL rst_unsigned0: got %b want 11", {if0.dsp_unsigned_a_o, if0.dsp_unsigned_b_o}); end
    n_checks++; if ({if1.dsp_unsigned_a_o, if1.dsp_unsigned_b_o} !== 2'b01) begin n_fail++; $display("FAIL rst_unsigned1: got %b want 01", {if1.dsp_unsigned_a_o, if1.dsp_unsigned_b_o}); end
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++; if (if0.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready0: got %b want 1", if0.req_ready_o); end
    n_checks++; if (if1.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready1: got %b want 1", if1.req_ready_o); end
    tick();
  endtask

  task automatic test_single_tap();
    send_tap0(10'h005, 9'h003, 1'b1);
    n_checks++; if (if0.dsp_a_o !== 10'h005) begin n_fail++; $display("FAIL single_a: got %h want 005", if0.dsp_a_o); end
    n_checks++; if (if0.dsp_b_o !== 9'h003) begin n_fail++; $display("FAIL single_b: got %h want 003", if0.dsp_b_o); end
    n_checks++; if (if0.dsp_feedback_o !== 3'b100) begin n_fail++; $display("FAIL single_fb: got %b want 100", if0.dsp_feedback_o); end
    n_checks++; if (if0.dsp_load_acc_o !== 1'b1) begin n_fail++; $display("FAIL single_load: got %b want 1", if0.dsp_load_acc_o); end
    n_checks++; if (if0.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL single_ready_wait: got %b want 0", if0.req_ready_o); end
    arm_z0(19'h00038);
    n_checks++; if ({if0.dsp_a_o, if0.dsp_b_o, if0.dsp_feedback_o, if0.dsp_load_acc_o} !== 23'h0) begin n_fail++; $display("FAIL single_tap_once: got a=%h b=%h fb=%b ld=%b want zeros", if0.dsp_a_o, if0.dsp_b_o, if0.dsp_feedback_o, if0.dsp_load_acc_o); end
    n_checks++; if (if0.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %b want 0", if0.res_valid_o); end
    tick();
    if0.dsp_z_i = ZJUNK;
    n_checks++; if (if0.res_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", if0.res_valid_o); end
    n_checks++; if (if0.res_data_o !== 19'h00038) begin n_fail++; $display("FAIL single_data: got %h want 00038", if0.res_data_o); end
    n_checks++; if (if0.res_taps_o !== 3'd1) begin n_fail++; $display("FAIL single_taps: got %0d want 1", if0.res_taps_o); end
    take_result0();
    n_checks++; if (if0.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", if0.res_valid_o); end
    n_checks++; if (if0.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %b want 1", if0.req_ready_o); end
  endtask

  task automatic test_three_tap();
    send_tap0(10'h007, 9'h001, 1'b0);
    n_checks++; if ({if0.dsp_feedback_o, if0.dsp_load_acc_o, if0.dsp_a_o, if0.dsp_b_o} !== {3'b100, 1'b1, 10'h007, 9'h001}) begin n_fail++; $display("FAIL three_t0: got fb=%b ld=%b a=%h b=%h want 100 1 007 001", if0.dsp_feedback_o, if0.dsp_load_acc_o, if0.dsp_a_o, if0.dsp_b_o); end
    send_tap0(10'h007, 9'h002, 1'b0);
    n_checks++; if ({if0.dsp_feedback_o, if0.dsp_load_acc_o, if0.dsp_a_o, if0.dsp_b_o} !== {3'b101, 1'b0, 10'h000, 9'h002}) begin n_fail++; $display("FAIL three_t1: got fb=%b ld=%b a=%h b=%h want 101 0 000 002", if0.dsp_feedback_o, if0.dsp_load_acc_o, if0.dsp_a_o, if0.dsp_b_o); end
    send_tap0(10'h007, 9'h003, 1'b1);
    n_checks++; if ({if0.dsp_feedback_o, if0.dsp_load_acc_o, if0.dsp_a_o, if0.dsp_b_o} !== {3'b110, 1'b0, 10'h000, 9'h003}) begin n_fail++; $display("FAIL three_t2: got fb=%b ld=%b a=%h b=%h want 110 0 000 003", if0.dsp_feedback_o, if0.dsp_load_acc_o, if0.dsp_a_o, if0.dsp_b_o); end
    arm_z0(19'h12345);
    tick();
    if0.dsp_z_i = ZJUNK;
    n_checks++; if (if0.res_taps_o !== 3'd3) begin n_fail++; $display("FAIL three_taps: got %0d want 3", if0.res_taps_o); end
    n_checks++; if (if0.res_data_o !== 19'h12345) begin n_fail++; $display("FAIL three_data: got %h want 12345", if0.res_data_o); end
    take_result0();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 3; i++) send_tap0(10'h00A, 9'(i), 1'b0);
    n_checks++; if (if0.err_overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_err_early: got %b want 0", if0.err_overflow_o); end
    send_tap0(10'h00A, 9'h004, 1'b0);
    n_checks++; if (if0.dsp_feedback_o !== 3'b111) begin n_fail++; $display("FAIL ovf_fb4: got %b want 111", if0.dsp_feedback_o); end
    n_checks++; if (if0.err_overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_err: got %b want 1", if0.err_overflow_o); end
    n_checks++; if (if0.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL ovf_forced_last: got ready %b want 0", if0.req_ready_o); end
    arm_z0(19'h00ABC);
    tick();
    if0.dsp_z_i = ZJUNK;
    n_checks++; if (if0.res_taps_o !== 3'd4) begin n_fail++; $display("FAIL ovf_taps: got %0d want 4", if0.res_taps_o); end
    n_checks++; if (if0.res_data_o !== 19'h00ABC) begin n_fail++; $display("FAIL ovf_data: got %h want 00ABC", if0.res_data_o); end
    take_result0();
    send_tap0(10'h001, 9'h001, 1'b1);
    arm_z0(19'h00011);
    tick();
    if0.dsp_z_i = ZJUNK;
    n_checks++; if (if0.res_taps_o !== 3'd1) begin n_fail++; $display("FAIL ovf_next_taps: got %0d want 1", if0.res_taps_o); end
    n_checks++; if (if0.err_overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", if0.err_overflow_o); end
    take_result0();
  endtask

  task automatic test_backpressure();
    send_tap0(10'h002, 9'h002, 1'b1);
    arm_z0(19'h33333);
    tick();
    if0.dsp_z_i     = ZJUNK;
    if0.req_valid_i = 1'b1;
    if0.req_b_i     = 9'h1FF;
    if0.req_last_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({if0.res_valid_o, if0.res_data_o, if0.res_taps_o, if0.req_ready_o} !== {1'b1, 19'h33333, 3'd1, 1'b0}) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h t=%0d rdy=%b want 1 33333 1 0", i, if0.res_valid_o, if0.res_data_o, if0.res_taps_o, if0.req_ready_o); end
      n_checks++; if (if0.dsp_b_o !== 9'h000) begin n_fail++; $display("FAIL bp_ignored[%0d]: got dsp_b %h want 000", i, if0.dsp_b_o); end
      tick();
    end
    take_result0();
    n_checks++; if ({if0.res_valid_o, if0.req_ready_o} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got v=%b rdy=%b want 0 1", if0.res_valid_o, if0.req_ready_o); end
    n_checks++; if ({if0.dsp_load_acc_o, if0.dsp_b_o} !== 10'h000) begin n_fail++; $display("FAIL bp_no_bypass: got ld=%b b=%h want 0 000", if0.dsp_load_acc_o, if0.dsp_b_o); end
    if0.req_valid_i = 1'b0;
    if0.req_last_i  = 1'b0;
    if0.req_b_i     = 9'h000;
  endtask

  task automatic test_latency7();
    if1.req_valid_i = 1'b1;
    if1.req_a_i     = 10'h005;
    if1.req_b_i     = 9'h003;
    if1.req_last_i  = 1'b1;
    tick();
    if1.req_valid_i = 1'b0;
    if1.req_last_i  = 1'b0;
    n_checks++; if ({if1.dsp_feedback_o, if1.dsp_load_acc_o} !== 4'b1001) begin n_fail++; $display("FAIL l7_tap: got fb=%b ld=%b want 100 1", if1.dsp_feedback_o, if1.dsp_load_acc_o); end
    for (int i = 0; i < LAT1; i++) begin
      n_checks++; if (if1.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL l7_early[%0d]: got %b want 0", i, if1.res_valid_o); end
      tick();
    end
    if1.dsp_z_i = 19'h71234;
    n_checks++; if (if1.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL l7_early_last: got %b want 0", if1.res_valid_o); end
    tick();
    if1.dsp_z_i = ZJUNK;
    n_checks++; if ({if1.res_valid_o, if1.res_data_o} !== {1'b1, 19'h71234}) begin n_fail++; $display("FAIL l7_result: got v=%b d=%h want 1 71234", if1.res_valid_o, if1.res_data_o); end
    if1.res_ready_i = 1'b1;
    tick();
    if1.res_ready_i = 1'b0;
    n_checks++; if ({if1.res_valid_o, if1.req_ready_o} !== 2'b01) begin n_fail++; $display("FAIL l7_release: got v=%b rdy=%b want 0 1", if1.res_valid_o, if1.req_ready_o); end
  endtask

  task automatic test_reset_in_wait();
    send_tap0(10'h005, 9'h003, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if ({if0.dsp_a_o, if0.dsp_b_o, if0.dsp_feedback_o, if0.dsp_load_acc_o} !== 23'h0) begin n_fail++; $display("FAIL rw_dsp: got a=%h b=%h fb=%b ld=%b want zeros", if0.dsp_a_o, if0.dsp_b_o, if0.dsp_feedback_o, if0.dsp_load_acc_o); end
    n_checks++; if ({if0.req_ready_o, if0.res_valid_o, if0.err_overflow_o} !== 3'b000) begin n_fail++; $display("FAIL rw_flags: got rdy=%b v=%b err=%b want 0 0 0", if0.req_ready_o, if0.res_valid_o, if0.err_overflow_o); end
    n_checks++; if ({if0.res_data_o, if0.res_taps_o} !== 22'h0) begin n_fail++; $display("FAIL rw_result: got d=%h t=%0d want 0 0", if0.res_data_o, if0.res_taps_o); end
    n_checks++; if ({if0.dsp_output_select_o, if0.dsp_unsigned_a_o, if0.dsp_unsigned_b_o} !== 5'b01111) begin n_fail++; $display("FAIL rw_const: got sel=%0d ua=%b ub=%b want 3 1 1", if0.dsp_output_select_o, if0.dsp_unsigned_a_o, if0.dsp_unsigned_b_o); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (if0.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rw_ready: got %b want 1", if0.req_ready_o); end
    if0.dsp_z_i = 19'h00038;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (if0.res_valid_o !== 1'b0) begin n_fail++; $display("FAIL rw_no_result[%0d]: got %b want 0", i, if0.res_valid_o); end
    end
    if0.dsp_z_i = ZJUNK;
  endtask

  initial begin
    if0.req_valid_i = 1'b0; if0.req_a_i = '0; if0.req_b_i = '0; if0.req_last_i = 1'b0;
    if0.res_ready_i = 1'b0; if0.dsp_z_i = ZJUNK;
    if1.req_valid_i = 1'b0; if1.req_a_i = '0; if1.req_b_i = '0; if1.req_last_i = 1'b0;
    if1.res_ready_i = 1'b0; if1.dsp_z_i = ZJUNK;

    test_reset();
    test_single_tap();
    test_three_tap();
    test_overflow();
    test_backpressure();
    test_latency7();
    test_reset_in_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/madd_cfg_sequencer.md
MADD_CFG_SEQUENCER -- requirements
Module: madd_cfg_sequencer

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning cycles from a tap driven on the DSP-side ports to a valid dsp_z_i; legal range 1..7.
REQ-002 SHALL have parameter UNSIGNED_A, default 1'b1, meaning the constant driven on dsp_unsigned_a_o.
REQ-003 SHALL have parameter UNSIGNED_B, default 1'b1, meaning the constant driven on dsp_unsigned_b_o.
REQ-004 SHALL have port clock_i  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid_i  input  1  tap request valid.
REQ-007 SHALL have port req_ready_o  output  1  tap request ready.
REQ-008 SHALL have port req_a_i  input  10  addend; used on the first tap of a burst only.
REQ-009 SHALL have port req_b_i  input  9  tap sample.
REQ-010 SHALL have port req_last_i  input  1  marks the last tap of a burst.
REQ-011 SHALL have port res_valid_o  output  1  result valid.
REQ-012 SHALL have port res_ready_i  input  1  result ready.
REQ-013 SHALL have port res_data_o  output  19  captured DSP result.
REQ-014 SHALL have port res_taps_o  output  3  number of taps in the burst, 1..4.
REQ-015 SHALL have port err_overflow_o  output  1  sticky tap-overflow flag.
REQ-016 SHALL have DSP-side ports dsp_a_o (10), dsp_b_o (9), dsp_feedback_o (3), dsp_load_acc_o (1), dsp_output_select_o (3), dsp_unsigned_a_o (1), dsp_unsigned_b_o (1), all outputs, and dsp_z_i (19) input.

Function
REQ-017 SHALL implement states IDLE, BURST, WAIT, RESULT.
REQ-018 SHALL assert req_ready_o only in IDLE and BURST.
REQ-019 SHALL count a tap as accepted on the cycle req_valid_i and req_ready_o are both high.
REQ-020 SHALL register all DSP-side outputs, so an accepted tap appears on them exactly one cycle after acceptance, for exactly one cycle.
REQ-021 SHALL drive the following for the accepted tap with index k (0..3, k=0 first): dsp_b_o=req_b_i, dsp_feedback_o={1'b1,k[1:0]}, dsp_load_acc_o=(k==0), dsp_a_o=(k==0 ? req_a_i : 0).
REQ-022 SHALL drive the following on cycles with no tap issue: dsp_a_o=0, dsp_b_o=0, dsp_feedback_o=3'b000, dsp_load_acc_o=0.
REQ-023 SHALL hold dsp_output_select_o at 3'd3 and dsp_unsigned_a_o/dsp_unsigned_b_o at their parameter values at all times, including during reset.
REQ-024 SHALL make these transitions: IDLE->BURST on an accepted tap without last; IDLE->WAIT on an accepted tap with last; BURST->WAIT on an accepted tap with last.
REQ-025 SHALL force last on the 4th accepted tap (k=3) even when req_last_i=0, and set err_overflow_o; the flag clears only on reset.
REQ-026 SHALL, in WAIT, count so that for a last tap accepted at cycle t, dsp_z_i is sampled into res_data_o at edge t+1+LATENCY, and res_valid_o is high from cycle t+2+LATENCY.
REQ-027 SHALL set res_taps_o to k+1 of the last tap, and hold both res_data_o and res_taps_o stable while res_valid_o is high.
REQ-028 SHALL go RESULT->IDLE on res_valid_o & res_ready_i, with req_ready_o high in the next cycle.
REQ-029 SHALL accept no new tap on the same cycle a result handshake occurs (no RESULT->BURST bypass).
REQ-030 SHALL ignore req_* inputs while req_ready_o is low.

Reset
REQ-031 SHALL, while reset_i is high, force state=IDLE, req_ready_o=0, res_valid_o=0, res_data_o=0, res_taps_o=0, err_overflow_o=0, tap index=0, WAIT counter=0, and the DSP-side outputs to their REQ-022/REQ-023 values.
REQ-032 SHALL abandon any burst, wait or held result on reset assertion mid-operation, with no result emitted afterwards.
REQ-033 SHALL assert req_ready_o in the first cycle after reset_i deasserts.

Verification
REQ-034 SHALL cover a single-tap burst: a=0x005, b=0x003, last=1 accepted at t -> next cycle a=0x005, b=0x003, feedback=3'b100, load_acc=1; stub z=0x00038 -> res_data_o=0x00038, res_taps_o=1, res_valid_o high from t+3 (LATENCY=1).
REQ-035 SHALL cover a 3-tap burst with b=1,2,3 on back-to-back cycles -> feedback 100,101,110 on consecutive cycles; load_acc high only on the first; dsp_a_o zero on taps 2-3; res_taps_o=3.
REQ-036 SHALL cover overflow: 4 taps with last=0 -> 4th treated as last, err_overflow_o=1 and staying 1 through later bursts, res_taps_o=4.
REQ-037 SHALL cover backpressure: res_ready_i held low 5 cycles -> res_valid_o, res_data_o, res_taps_o stable and req_ready_o=0 throughout; on the handshake -> IDLE, req_ready_o=1 on the next cycle.
REQ-038 SHALL cover LATENCY=7: last tap at t -> z sampled at edge t+8, res_valid_o high from t+9.
REQ-039 SHALL cover reset in WAIT: reset_i pulsed asynchronously between edges -> outputs at reset values immediately, no res_valid_o afterwards, req_ready_o=1 on the first cycle after release.
